// File: rtl/rr_arbiter_buf_pkg.sv
// Shared helpers for the N-to-1 arbiter with registered output buffer.
// Holds the index-width helper used by the top level and the picker.
// No state and no logic; the package is imported by both RTL files.
package rr_arbiter_buf_pkg;

  // Width of a binary channel index. The legal channel count is at least 2,
  // so the result is never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_buf_pick.sv
// Round-robin picker. Returns a one-hot grant and its binary index for the
// first request above ptr, with wrap-around. It is purely combinational and
// adds no latency. It has no backpressure of its own, and the grant is zero
// when nothing requests.
module rr_pick
  import rr_arbiter_buf_pkg::*;
#(
  parameter int NUM   = 4,
  parameter int IDX_W = idx_width(NUM)
) (
  input  logic [NUM-1:0]   valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [NUM-1:0]   grant,
  output logic [IDX_W-1:0] grant_idx
);

  // Requests strictly above the last served channel.
  logic [NUM-1:0]   mask;
  // The masked requests sit in the low half and the full request vector
  // sits in the high half. The lowest set bit is therefore the first
  // request after ptr, and the search wraps onto the unmasked copy when
  // nothing lies above ptr.
  logic [2*NUM-1:0] dbl;
  logic             hit;
  int               pos;
  int               sel_ch;

  // Mask out every channel at or below the pointer.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM; i++) begin
      mask[i] = (i > int'(ptr));
    end
  end

  assign dbl = {valid, valid & mask};

  // Lowest set bit of the double-width vector.
  always_comb begin
    hit = 1'b0;
    pos = 0;
    for (int i = 2*NUM-1; i >= 0; i--) begin
      if (dbl[i]) begin
        hit = 1'b1;
        pos = i;
      end
    end
  end

  // Fold the double-width position back onto a channel number and build the
  // one-hot grant.
  always_comb begin
    sel_ch    = (pos >= NUM) ? (pos - NUM) : pos;
    grant_idx = IDX_W'(sel_ch);
    grant     = '0;
    for (int i = 0; i < NUM; i++) begin
      grant[i] = hit && (sel_ch == i);
    end
  end

endmodule

// File: rtl/rr_arbiter_buf.sv
// N-to-1 valid/ready arbiter with a one-entry registered output buffer.
// Latency: an accept at edge k shows valid_o in cycle k+1, at 1 transfer per cycle.
// Backpressure: ready is zero while the buffer is full and ready_o is low.
module rr_arbiter_buf
  import rr_arbiter_buf_pkg::*;
#(
  parameter int NUM        = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RR         = 1,
  localparam int IDX_W     = idx_width(NUM)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM-1:0]                 valid,
  input  logic [NUM-1:0][DATA_WIDTH-1:0] data,
  output logic [NUM-1:0]                 ready,
  output logic                           valid_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic [IDX_W-1:0]               idx_o,
  input  logic                           ready_o
);

  logic             space;
  logic             accept;
  logic [NUM-1:0]   grant;
  logic [IDX_W-1:0] grant_idx;

  // The buffer can take a new word when it is empty or when it drains in
  // the same cycle.
  assign space  = ~valid_o | ready_o;
  assign ready  = grant & {NUM{space}};
  assign accept = |(valid & ready);

  if (RR == 1) begin : g_rr
    // The last channel served. Reset to NUM-1 so that channel 0 is looked
    // at first.
    logic [IDX_W-1:0] ptr;

    rr_pick #(
      .NUM   (NUM),
      .IDX_W (IDX_W)
    ) u_pick (
      .valid     (valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
    );

    // The pointer moves only on a transfer that is actually taken. A grant
    // that is held off by backpressure does not move it.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ptr <= IDX_W'(NUM - 1);
      end else if (accept) begin
        ptr <= grant_idx;
      end
    end
  end else begin : g_fixed
    logic fp_hit;
    int   fp_ch;

    // Fixed priority: the highest-index requester wins.
    always_comb begin
      fp_hit = 1'b0;
      fp_ch  = 0;
      for (int i = 0; i < NUM; i++) begin
        if (valid[i]) begin
          fp_hit = 1'b1;
          fp_ch  = i;
        end
      end
      grant_idx = IDX_W'(fp_ch);
      grant     = '0;
      for (int i = 0; i < NUM; i++) begin
        grant[i] = fp_hit && (fp_ch == i);
      end
    end
  end

  // Output buffer. A new word replaces the old one, including when both
  // happen in the same cycle. A drain with no refill only clears valid_o,
  // and data_o and idx_o keep their last values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      idx_o   <= '0;
    end else if (accept) begin
      valid_o <= 1'b1;
      data_o  <= data[grant_idx];
      idx_o   <= grant_idx;
    end else if (ready_o) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_buf.sv
// Bench for rr_arbiter_buf, covering the round-robin and fixed-priority builds.
// It applies one vector table per build and one extra full-load run, and the
// expected outputs go through a queue to be compared one cycle later.
module tb_rr_arbiter_buf;

  logic clk;

  logic             rr_rst, rr_ro, rr_vo;
  logic [3:0]       rr_valid, rr_ready;
  logic [31:0]      rr_dat;
  logic [1:0]       rr_idx;

  logic             fp_rst, fp_ro, fp_vo;
  logic [3:0]       fp_valid, fp_ready;
  logic [31:0]      fp_dat;
  logic [1:0]       fp_idx;

  logic [3:0][31:0] data_in;

  int total;
  int bad;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic        ro;
    logic        chk_rdy;
    logic [3:0]  exp_rdy;
    logic        exp_vo;
    logic [1:0]  exp_idx;
    logic [31:0] exp_dat;
  } vec_t;

  typedef struct packed {
    logic        vo;
    logic [1:0]  idx;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];

  vec_t rr_tab[19];
  vec_t fp_tab[10];

  rr_arbiter_buf #(.NUM(4), .DATA_WIDTH(32), .RR(1)) dut_rr (
    .clk     (clk),
    .rst_n   (rr_rst),
    .valid   (rr_valid),
    .data    (data_in),
    .ready   (rr_ready),
    .valid_o (rr_vo),
    .data_o  (rr_dat),
    .idx_o   (rr_idx),
    .ready_o (rr_ro)
  );

  rr_arbiter_buf #(.NUM(4), .DATA_WIDTH(32), .RR(0)) dut_fp (
    .clk     (clk),
    .rst_n   (fp_rst),
    .valid   (fp_valid),
    .data    (data_in),
    .ready   (fp_ready),
    .valid_o (fp_vo),
    .data_o  (fp_dat),
    .idx_o   (fp_idx),
    .ready_o (fp_ro)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic ro,
                              input logic chk_rdy, input logic [3:0] rdy, input logic vo,
                              input logic [1:0] idx, input logic [31:0] dat);
    vec_t v;
    v.rst = rst; v.valid = valid; v.ro = ro; v.chk_rdy = chk_rdy;
    v.exp_rdy = rdy; v.exp_vo = vo; v.exp_idx = idx; v.exp_dat = dat;
    return v;
  endfunction

  // Drive one cycle, check ready in the same cycle, then check the
  // registered outputs after the edge against the queued expectation.
  task automatic run_row(input bit fp, input vec_t v, input string tag);
    exp_t e;
    logic [3:0] rdy;
    if (fp) begin
      fp_rst = v.rst; fp_valid = v.valid; fp_ro = v.ro;
    end else begin
      rr_rst = v.rst; rr_valid = v.valid; rr_ro = v.ro;
    end
    #1;
    rdy = fp ? fp_ready : rr_ready;
    if (v.chk_rdy) chk({tag, ".ready"}, 32'(rdy), 32'(v.exp_rdy));
    exp_q.push_back('{vo: v.exp_vo, idx: v.exp_idx, dat: v.exp_dat});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s.queue actual=empty required=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".valid_o"}, 32'(fp ? fp_vo : rr_vo), 32'(e.vo));
      chk({tag, ".idx_o"}, 32'(fp ? fp_idx : rr_idx), 32'(e.idx));
      chk({tag, ".data_o"}, fp ? fp_dat : rr_dat, e.dat);
    end
  endtask

  initial begin
    int ch;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 4; i++) data_in[i] = 32'hA0 + 32'(i);
    rr_rst = 1'b0; rr_valid = '0; rr_ro = 1'b0;
    fp_rst = 1'b0; fp_valid = '0; fp_ro = 1'b0;

    // Round-robin build:          rst valid  ro  chk rdy   vo idx dat
    rr_tab[0]  = mk(1'b0, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 32'h0);
    rr_tab[1]  = mk(1'b0, 4'hF, 1'b1, 1'b1, 4'h1, 1'b0, 2'd0, 32'h0);
    rr_tab[2]  = mk(1'b1, 4'hF, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0, 32'hA0);
    rr_tab[3]  = mk(1'b1, 4'hF, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1, 32'hA1);
    rr_tab[4]  = mk(1'b1, 4'hF, 1'b1, 1'b1, 4'h4, 1'b1, 2'd2, 32'hA2);
    rr_tab[5]  = mk(1'b1, 4'hF, 1'b0, 1'b1, 4'h0, 1'b1, 2'd2, 32'hA2);
    rr_tab[6]  = mk(1'b1, 4'hF, 1'b0, 1'b1, 4'h0, 1'b1, 2'd2, 32'hA2);
    rr_tab[7]  = mk(1'b1, 4'hF, 1'b0, 1'b1, 4'h0, 1'b1, 2'd2, 32'hA2);
    rr_tab[8]  = mk(1'b1, 4'hF, 1'b1, 1'b1, 4'h8, 1'b1, 2'd3, 32'hA3);
    rr_tab[9]  = mk(1'b1, 4'hF, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0, 32'hA0);
    rr_tab[10] = mk(1'b1, 4'hF, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1, 32'hA1);
    rr_tab[11] = mk(1'b1, 4'h9, 1'b1, 1'b1, 4'h8, 1'b1, 2'd3, 32'hA3);
    rr_tab[12] = mk(1'b1, 4'h9, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0, 32'hA0);
    rr_tab[13] = mk(1'b1, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 32'hA0);
    rr_tab[14] = mk(1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 32'hA0);
    rr_tab[15] = mk(1'b1, 4'h8, 1'b1, 1'b1, 4'h8, 1'b1, 2'd3, 32'hA3);
    rr_tab[16] = mk(1'b0, 4'hF, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0);
    rr_tab[17] = mk(1'b1, 4'hF, 1'b0, 1'b1, 4'h1, 1'b1, 2'd0, 32'hA0);
    rr_tab[18] = mk(1'b1, 4'hF, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1, 32'hA1);

    // Fixed-priority build, highest index wins
    fp_tab[0]  = mk(1'b0, 4'h6, 1'b1, 1'b1, 4'h4, 1'b0, 2'd0, 32'h0);
    for (int i = 1; i <= 5; i++)
      fp_tab[i] = mk(1'b1, 4'h6, 1'b1, 1'b1, 4'h4, 1'b1, 2'd2, 32'hA2);
    fp_tab[6]  = mk(1'b1, 4'h2, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1, 32'hA1);
    fp_tab[7]  = mk(1'b1, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd1, 32'hA1);
    fp_tab[8]  = mk(1'b1, 4'hF, 1'b0, 1'b1, 4'h8, 1'b1, 2'd3, 32'hA3);
    fp_tab[9]  = mk(1'b1, 4'hF, 1'b0, 1'b1, 4'h0, 1'b1, 2'd3, 32'hA3);

    for (int i = 0; i < 19; i++) run_row(1'b0, rr_tab[i], $sformatf("rr[%0d]", i));

    // Full load continues from the last served channel 1. Expect a strict
    // rotation starting at channel 2, with one transfer per cycle.
    for (int k = 0; k < 8; k++) begin
      ch = (2 + k) % 4;
      run_row(1'b0, mk(1'b1, 4'hF, 1'b1, 1'b1, 4'(1 << ch), 1'b1, 2'(ch), 32'hA0 + 32'(ch)),
              $sformatf("rr_load[%0d]", k));
    end

    for (int i = 0; i < 10; i++) run_row(1'b1, fp_tab[i], $sformatf("fp[%0d]", i));

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_buf.md
# rr_arbiter_buf

Parametrised N-to-1 arbiter with valid/ready handshake on every input and on the output, plus a one-entry registered output buffer. It generalises the fixed-priority two- and three-input arbiters in the utils library to any channel count. It adds a selectable round-robin fairness mode and a registered, backpressure-aware output. It sits in `src/utils` and is used wherever several producers (LSU ports, refill paths, writeback sources) share one downstream consumer.

## Interface
- `NUM`, 4: number of input channels; legal range 2..32.
- `DATA_WIDTH`, 32: payload width per channel.
- `RR`, 1: 1 = round-robin; 0 = fixed priority, where the highest index wins.
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `valid`  in  NUM  per-channel request.
- `data`  in  NUM x DATA_WIDTH  per-channel payload, packed as [NUM-1:0][DATA_WIDTH-1:0].
- `ready`  out  NUM  per-channel accept; at most one bit is set.
- `valid_o`  out  1  output buffer holds data.
- `data_o`  out  DATA_WIDTH  buffered payload.
- `idx_o`  out  IDX_W  index of the channel that produced `data_o`, where IDX_W = $clog2(NUM).
- `ready_o`  in  1  downstream accepts `data_o`.

## Operation
- **Buffer space.** `space = ~valid_o | ready_o`. The buffer may be refilled in the same cycle it drains.
- **Grant.** `grant` is a combinational one-hot over `valid`. It is zero when `valid == 0`.
  - RR=0: the highest-index valid channel wins.
  - RR=1: search upward from `(ptr+1) mod NUM` with wrap-around. The first valid channel found wins.
- **Ready.** `ready[i] = grant[i] & space`.
- **Accept.** An input is accepted when `valid[i] & ready[i]`. On accept:
  - `data_o` <= `data[i]`
  - `idx_o` <= i
  - `valid_o` <= 1
  - when RR=1, `ptr` <= i
- **Drain only.** If `valid_o & ready_o` and nothing is accepted, `valid_o` <= 0. `data_o` and `idx_o` keep their last values.
- **Hold.** If `valid_o & ~ready_o`:
  - `ready` is all-zero.
  - `data_o` and `idx_o` are stable.
  - `ptr` is unchanged.
- **Pointer updates.** `ptr` changes only on an accepted transfer. It never changes on a grant that is not accepted.
- **Input protocol.** Requesters must hold `valid` and `data` until accepted. The arbiter does not latch a grant: if the winning channel drops `valid`, a different channel may win in the same cycle.
- **Illegal input.** Behaviour with X on `valid` is unspecified. There is no error detection.

## Timing
- **Reset values.** On `rst_n` = 0:
  - `valid_o` = 0, `data_o` = 0, `idx_o` = 0.
  - `ptr` = NUM-1, so channel 0 has highest round-robin priority after reset.
  - `ready` is combinational and is all-zero whenever there is no request.
- **Reset mid-operation.** Buffered data is discarded. `ready` does not depend on reset, but `space` = 1 from the next cycle.
- **Latency.** Input accept at edge k gives `valid_o` = 1 in cycle k+1. Sustained throughput is 1 transfer per cycle while `ready_o` = 1.
- **Combinational paths.**
  - `valid` -> `ready` and `ready_o` -> `ready` are combinational.
  - `data_o`, `valid_o` and `idx_o` are registered, with no combinational path from the inputs.
- **Simultaneous drain and accept.** In the same cycle the new data replaces the old, and `valid_o` stays 1.

## Structure
- No shared-package typedefs. IDX_W is a local parameter.
- One sub-module, `rr_pick`, which is purely combinational.
  - Inputs: `valid[NUM-1:0]` and `ptr`.
  - Outputs: one-hot `grant` and binary `grant_idx`.
  - Implementation: a double-width masked priority search. Rotate the request vector using a mask generated from `ptr`. Fall back to the unmasked request vector when no request exists above `ptr`.
  - The top level instantiates `rr_pick` only when RR=1. When RR=0 it uses an inline highest-index priority select.
- The top level holds the output register, `ptr` and the handshake logic.

## Test plan
- **Reset.** Hold `rst_n` = 0 for 2 cycles with `valid` = 4'b1111.
  - During reset: `valid_o` = 0, `data_o` = 0, `idx_o` = 0.
  - First accept after release: channel 0.
- **Round-robin, full load.** NUM=4, RR=1, `valid` = 4'b1111 held, `ready_o` = 1, `data[i]` = 0xA0+i.
  - `idx_o` sequence from cycle 1: 0,1,2,3,0,1.
  - `data_o` sequence: A0,A1,A2,A3,A0.
- **Backpressure.** Buffer holds A2. Hold `ready_o` = 0 for 3 cycles.
  - `ready` = 0, `data_o` = A2 and `idx_o` = 2 throughout.
  - When `ready_o` = 1, the next `idx_o` is 3.
- **Wrap skip.** `ptr` = 1 and `valid` = 4'b1001.
  - Channel 3 is accepted, then channel 0. Channels 1 and 2 never get `ready`.
- **Fixed priority.** RR=0 with `valid` = 4'b0110 held for 5 accepts.
  - `idx_o` = 2 every time; channel 1 is starved.
  - Drop `valid[2]`: the next `idx_o` is 1.
- **Reset mid-operation.** With `valid_o` = 1 holding A3 and `ptr` = 3, assert `rst_n` = 0 for 1 cycle.
  - `valid_o` = 0 next cycle.
  - After release with `valid` = 4'b1111, the first accept is channel 0.
